cplx_div_sequencer: RTL and testbench

Upstream/downstream companion of the receiver's scalar divider. Accepts complex-numerator divide requests (I, Q, shared 24-bit divisor) and serialises them onto the single divider as two back-to-back scalar ops. Re-pairs the in-order quotients into complex results. Used by the equaliser and CFO paths wherever a complex value is normalised by a real magnitude.

---
 rtl/cplx_div_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_cplx_div_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cplx_div_sequencer.sv
// Serialises complex-numerator divide requests onto one scalar divider and re-pairs the quotients.
// Optional CPLX_DIV_SAT16_EN: saturate results to signed 16 bits, sign-extended to 32.
module cplx_div_sequencer #(
  parameter int IN_DEPTH        = 4,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] in_i,
  input  logic [31:0] in_q,
  input  logic [23:0] in_div,
  input  logic        in_strobe,
  output logic        in_ready,
  output logic [31:0] div_dividend,
  output logic [23:0] div_divisor,
  output logic        div_in_strobe,
  input  logic [31:0] div_quotient,
  input  logic        div_out_strobe,
  output logic [31:0] out_i,
  output logic [31:0] out_q,
  output logic        out_div0,
  output logic        out_strobe,
  output logic [1:0]  err
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int TAG_AW = $clog2(MAX_OUTSTANDING);
  localparam logic [IN_AW:0]  IN_FULL  = (IN_AW+1)'(IN_DEPTH);
  localparam logic [TAG_AW:0] TAG_FULL = (TAG_AW+1)'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE_I = 2'd1, ISSUE_Q = 2'd2} state_t;
  state_t state, state_nxt;

  logic [31:0] req_i_mem   [IN_DEPTH];
  logic [31:0] req_q_mem   [IN_DEPTH];
  logic [23:0] req_div_mem [IN_DEPTH];
  logic [IN_AW-1:0] req_wr, req_rd;
  logic [IN_AW:0]   req_cnt, req_cnt_nxt;
  logic req_push, req_pop, req_drop;

  logic tag_mem [MAX_OUTSTANDING];
  logic [TAG_AW-1:0] tag_wr, tag_rd;
  logic [TAG_AW:0]   tag_cnt;
  logic tag_push, tag_val, tag_pop, orphan;

  logic [31:0] dividend_d;
  logic [23:0] divisor_d;
  logic        strobe_d;
  logic        can_issue;
  logic        phase;
  logic [31:0] lat_i;

  function automatic logic [31:0] fmt_q(input logic [31:0] v);
`ifdef CPLX_DIV_SAT16_EN
    if ($signed(v) > 32'sd32767)       return 32'h0000_7FFF;
    else if ($signed(v) < -32'sd32768) return 32'hFFFF_8000;
    else                               return v;
`else
    return v;
`endif
  endfunction

  assign req_push  = in_strobe & enable & in_ready;
  assign req_drop  = in_strobe & enable & ~in_ready;
  assign can_issue = (req_cnt != '0) && enable && (tag_cnt < TAG_FULL);

  always_comb begin
    req_cnt_nxt = req_cnt;
    case ({req_push, req_pop})
      2'b10:   req_cnt_nxt = req_cnt + (IN_AW+1)'(1);
      2'b01:   req_cnt_nxt = req_cnt - (IN_AW+1)'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (req_push) begin
      req_i_mem[req_wr]   <= in_i;
      req_q_mem[req_wr]   <= in_q;
      req_div_mem[req_wr] <= in_div;
    end
    if (tag_push) tag_mem[tag_wr] <= tag_val;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      req_wr   <= '0;
      req_rd   <= '0;
      req_cnt  <= '0;
      in_ready <= 1'b0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      tag_cnt  <= '0;
    end else begin
      req_cnt  <= req_cnt_nxt;
      in_ready <= req_cnt_nxt < IN_FULL;
      if (req_push) req_wr <= req_wr + IN_AW'(1);
      if (req_pop)  req_rd <= req_rd + IN_AW'(1);
      if (tag_push) tag_wr <= tag_wr + TAG_AW'(1);
      if (tag_pop)  tag_rd <= tag_rd + TAG_AW'(1);
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + (TAG_AW+1)'(1);
        2'b01:   tag_cnt <= tag_cnt - (TAG_AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Divider outputs are registered from the next-state decode, so they line up with the state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      div_dividend  <= '0;
      div_divisor   <= '0;
      div_in_strobe <= 1'b0;
    end else begin
      state         <= state_nxt;
      div_dividend  <= dividend_d;
      div_divisor   <= divisor_d;
      div_in_strobe <= strobe_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = can_issue ? ISSUE_I : IDLE;
      ISSUE_I: state_nxt = ISSUE_Q;
      ISSUE_Q: state_nxt = can_issue ? ISSUE_I : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dividend_d = '0;
    divisor_d  = '0;
    strobe_d   = 1'b0;
    tag_push   = 1'b0;
    tag_val    = 1'b0;
    req_pop    = 1'b0;
    case (state_nxt)
      ISSUE_I: begin
        dividend_d = req_i_mem[req_rd];
        divisor_d  = req_div_mem[req_rd];
        strobe_d   = 1'b1;
        tag_push   = 1'b1;
        tag_val    = (req_div_mem[req_rd] == '0);
      end
      ISSUE_Q: begin
        dividend_d = req_q_mem[req_rd];
        divisor_d  = req_div_mem[req_rd];
        strobe_d   = 1'b1;
        req_pop    = 1'b1;
      end
      default: ;
    endcase
  end

  assign tag_pop = div_out_strobe & phase;
  assign orphan  = div_out_strobe & ~phase & (tag_cnt == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      phase      <= 1'b0;
      lat_i      <= '0;
      out_i      <= '0;
      out_q      <= '0;
      out_div0   <= 1'b0;
      out_strobe <= 1'b0;
      err        <= '0;
    end else begin
      out_strobe <= tag_pop;
      if (div_out_strobe && !phase && (tag_cnt != '0)) begin
        lat_i <= div_quotient;
        phase <= 1'b1;
      end
      if (tag_pop) begin
        phase <= 1'b0;
        if (tag_mem[tag_rd]) begin
          out_i    <= '0;
          out_q    <= '0;
          out_div0 <= 1'b1;
        end else begin
          out_i    <= fmt_q(lat_i);
          out_q    <= fmt_q(div_quotient);
          out_div0 <= 1'b0;
        end
      end
      if (req_drop) err[0] <= 1'b1;
      if (orphan)   err[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cplx_div_sequencer.sv
// Directed bench for cplx_div_sequencer with a pipelined scalar divider model of variable latency.
module tb_cplx_div_sequencer;

  logic        clock, reset, enable;
  logic [31:0] in_i, in_q;
  logic [23:0] in_div;
  logic        in_strobe, in_ready;
  logic [31:0] div_dividend;
  logic [23:0] div_divisor;
  logic        div_in_strobe;
  logic [31:0] div_quotient;
  logic        div_out_strobe;
  logic [31:0] out_i, out_q;
  logic        out_div0, out_strobe;
  logic [1:0]  err;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  cplx_div_sequencer #(.IN_DEPTH(4), .MAX_OUTSTANDING(32)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .in_i(in_i), .in_q(in_q), .in_div(in_div), .in_strobe(in_strobe), .in_ready(in_ready),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_in_strobe(div_in_strobe),
    .div_quotient(div_quotient), .div_out_strobe(div_out_strobe),
    .out_i(out_i), .out_q(out_q), .out_div0(out_div0), .out_strobe(out_strobe), .err(err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Divider model: D-stage pipeline, never reset.
  int unsigned lat = 36;
  bit        pipe_v [128];
  bit [31:0] pipe_q [128];

  function automatic bit [31:0] model_div(input logic [31:0] n, input logic [23:0] d);
    logic signed [31:0] ds;
    ds = {{8{d[23]}}, d};
    if (ds == 32'sd0) return 32'h5A5A_A5A5;
    return $signed(n) / ds;
  endfunction

  always @(posedge clock) begin
    for (int k = 127; k > 0; k--) begin
      pipe_v[k] <= pipe_v[k-1];
      pipe_q[k] <= pipe_q[k-1];
    end
    pipe_v[0] <= (div_in_strobe === 1'b1);
    pipe_q[0] <= model_div(div_dividend, div_divisor);
  end

  assign div_out_strobe = pipe_v[lat-1];
  assign div_quotient   = pipe_q[lat-1];

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] q;
    logic        d0;
  } exp_t;
  exp_t exp_q[$];

  int ops_in = 0, ops_out = 0, max_ops = 0, out_cnt = 0;

  always @(negedge clock) begin : mon
    exp_t e;
    if (div_in_strobe === 1'b1) ops_in++;
    if (div_out_strobe) ops_out++;
    if (ops_in - ops_out > max_ops) max_ops = ops_in - ops_out;
    if (out_strobe === 1'b1) begin
      out_cnt++;
      check_eq("out_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("out_i", 64'(out_i), 64'(e.i));
        check_eq("out_q", 64'(out_q), 64'(e.q));
        check_eq("out_div0", 64'(out_div0), 64'(e.d0));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send1(input logic [31:0] i, input logic [31:0] q, input logic [23:0] d, input exp_t e);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    in_i = i; in_q = q; in_div = d; in_strobe = 1'b1;
    exp_q.push_back(e);
    @(negedge clock);
    in_strobe = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check_eq(tag, 64'(exp_q.size()), 64'(0));
    idle(4);
  endtask

  int t_i, t_q, t_o, ops0, oc0, sent, guard;
  logic exp_rdy;
  logic [31:0] sat_i_exp, sat_q_exp;

  initial begin
    reset = 1'b0; enable = 1'b0; in_strobe = 1'b0;
    in_i = '0; in_q = '0; in_div = '0;
    idle(3);
    check_eq("rst_in_ready", 64'(in_ready), 64'(0));
    check_eq("rst_div_in_strobe", 64'(div_in_strobe), 64'(0));
    check_eq("rst_div_dividend", 64'(div_dividend), 64'(0));
    check_eq("rst_out_strobe", 64'(out_strobe), 64'(0));
    check_eq("rst_out_i", 64'(out_i), 64'(0));
    check_eq("rst_err", 64'(err), 64'(0));
    reset = 1'b1;
    idle(1);
    check_eq("in_ready_after_rst", 64'(in_ready), 64'(1));
    enable = 1'b1;

    // Single request: issue at t+1/t+2, result at t+39 with D=36
    in_i = 32'd1000; in_q = -32'sd500; in_div = 24'd10; in_strobe = 1'b1;
    exp_q.push_back('{32'd100, -32'sd50, 1'b0});
    @(negedge clock);
    in_strobe = 1'b0;
    check_eq("lat_t0_no_issue", 64'(div_in_strobe), 64'(0));
    t_i = 0; t_q = 0; t_o = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (k == 1) check_eq("issue_i_dividend", 64'(div_dividend), 64'(32'd1000));
      if (k == 2) begin
        check_eq("issue_q_dividend", 64'(div_dividend), 64'(32'hFFFF_FE0C));
        check_eq("issue_q_divisor", 64'(div_divisor), 64'(24'd10));
      end
      if (div_in_strobe && t_i == 0) t_i = k;
      else if (div_in_strobe && t_q == 0) t_q = k;
      if (out_strobe && t_o == 0) t_o = k;
    end
    check_eq("lat_issue_i", 64'(t_i), 64'(1));
    check_eq("lat_issue_q", 64'(t_q), 64'(2));
    check_eq("lat_out", 64'(t_o), 64'(39));
    wait_drain(50, "drain_single");

    // Strobe with enable low is ignored without error
    ops0 = ops_in;
    enable = 1'b0; in_i = 32'd5; in_q = 32'd5; in_div = 24'd1; in_strobe = 1'b1;
    idle(1);
    in_strobe = 1'b0;
    idle(5);
    check_eq("dis_no_issue", 64'(ops_in - ops0), 64'(0));
    check_eq("dis_no_err", 64'(err), 64'(0));
    enable = 1'b1;

    // Divide by zero, then a normal request
    send1(32'd7, 32'd7, 24'd0, '{32'd0, 32'd0, 1'b1});
    send1(-32'sd90, 32'd45, -24'sd9, '{32'd10, -32'sd5, 1'b0});
    wait_drain(100, "drain_div0");
    check_eq("err_before_burst", 64'(err), 64'(0));

    // Burst: strobe every cycle; FIFO of 4 drains one per 2 cycles
    for (int k = 0; k < 20; k++) begin
      exp_rdy = (k < 6) || (k % 2 == 1);
      check_eq("burst_rdy", 64'(in_ready), 64'(exp_rdy));
      in_i = 32'((k + 1) * 100); in_q = 32'(-(k + 1) * 30); in_div = 24'd10;
      in_strobe = 1'b1;
      if (exp_rdy) exp_q.push_back('{32'((k + 1) * 10), 32'(-(k + 1) * 3), 1'b0});
      @(negedge clock);
    end
    in_strobe = 1'b0;
    wait_drain(300, "drain_burst");
    check_eq("err_drop", 64'(err), 64'(2'b01));

    // Saturation option
`ifdef CPLX_DIV_SAT16_EN
    sat_i_exp = 32'h0000_7FFF; sat_q_exp = 32'hFFFF_8000;
`else
    sat_i_exp = 32'd10000000;  sat_q_exp = -32'sd10000000;
`endif
    send1(32'd10000000, -32'sd10000000, 24'd1, '{sat_i_exp, sat_q_exp, 1'b0});
    wait_drain(100, "drain_sat");

    // Long latency: issue must stall at 32 pairs in flight
    idle(130);
    lat = 80;
    max_ops = ops_in - ops_out;
    sent = 0; guard = 0;
    while (sent < 40 && guard < 2000) begin
      if (in_ready === 1'b1) begin
        in_i = 32'(3 * (sent + 1)); in_q = 32'(-3 * (sent + 1) - 1); in_div = 24'd3;
        in_strobe = 1'b1;
        exp_q.push_back('{32'(sent + 1), 32'(-(sent + 1)), 1'b0});
        sent++;
      end else begin
        in_strobe = 1'b0;
      end
      @(negedge clock);
      guard++;
    end
    in_strobe = 1'b0;
    check_eq("lat80_sent", 64'(sent), 64'(40));
    wait_drain(800, "drain_lat80");
    check_eq("max_outstanding_ops", 64'(max_ops), 64'(64));

    // Reset mid-stream with the divider left running
    idle(130);
    lat = 36;
    for (int k = 0; k < 6; k++) begin
      in_i = 32'(k + 11); in_q = 32'(k + 12); in_div = 24'd1; in_strobe = 1'b1;
      @(negedge clock);
    end
    in_strobe = 1'b0;
    idle(4);
    reset = 1'b0;
    idle(2);
    exp_q.delete();
    reset = 1'b1;
    oc0 = out_cnt;
    idle(1);
    check_eq("err_cleared_by_rst", 64'(err), 64'(0));
    idle(80);
    check_eq("stale_no_out", 64'(out_cnt - oc0), 64'(0));
    check_eq("err_orphan", 64'(err), 64'(2'b10));
    send1(32'd1000, -32'sd500, 24'd10, '{32'd100, -32'sd50, 1'b0});
    wait_drain(100, "drain_after_rst");
    check_eq("err_sticky", 64'(err), 64'(2'b10));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
